ctrl_pipe: RTL and testbench

Pipelined main control unit for the 5-stage MIPS core. Decodes the 6-bit opcode in ID and carries the resulting control bundle through ID/EX, EX/MEM and MEM/WB registers. It supports EX-stage stall and flush, bubble insertion, and an optional extended I-type set (ANDI/ORI/SLTI). The datapath consumes each control field directly from the stage that uses it.

---
 rtl/ctrl_pipe.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined main control unit for the 5-stage MIPS core.
// Decodes the ID-stage opcode into a control bundle. The bundle then moves
// through the ID/EX, EX/MEM and MEM/WB registers. Each stage drives its own
// control outputs.
//
// Parameter:
//   EXT_ITYPE  1 = decode ANDI/ORI/SLTI, 0 = treat them as illegal
// Build option:
//   CTRL_PIPE_ILLEGAL_TRAP_EN  carry an illegal bit to WB; drive illegal_w
//                              and the sticky illegal_seen flag
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   opcode_d, valid_d    ID-stage opcode and its valid qualifier
//   stall_e, flush_e     hold / bubble the ID/EX register (flush wins)
//   branch_d, jump_d     ID-stage combinational controls
//   *_e                  EX-stage controls and hazard-unit copies
//   *_m                  MEM-stage controls
//   *_w                  WB-stage controls
//   illegal_w            illegal opcode reached WB (one-cycle pulse)
//   illegal_seen         sticky illegal flag, cleared only by reset
module ctrl_pipe #(
  parameter bit EXT_ITYPE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode_d,
  input  logic       valid_d,
  input  logic       stall_e,
  input  logic       flush_e,
  output logic       branch_d,
  output logic       jump_d,
  output logic       reg_dst_e,
  output logic       alu_src_e,
  output logic       ext_zero_e,
  output logic       jal_wa_sel_e,
  output logic [2:0] alu_op_e,
  output logic       we_reg_e,
  output logic       dm2reg_e,
  output logic       valid_e,
  output logic       we_dm_m,
  output logic       we_reg_m,
  output logic       dm2reg_m,
  output logic       jal_wd_sel_m,
  output logic       valid_m,
  output logic       we_reg_w,
  output logic       dm2reg_w,
  output logic       jal_wd_sel_w,
  output logic       valid_w,
  output logic       illegal_w,
  output logic       illegal_seen
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_SLTI  = 6'h0A,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101
  } alu_op_t;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    ext_zero;
    logic    jal_wa_sel;
    alu_op_t alu_op;
    logic    we_reg;
    logic    dm2reg;
    logic    we_dm;
    logic    jal_wd_sel;
    logic    valid;
  } ex_t;

  typedef struct packed {
    logic we_dm;
    logic we_reg;
    logic dm2reg;
    logic jal_wd_sel;
    logic valid;
  } mem_t;

  typedef struct packed {
    logic we_reg;
    logic dm2reg;
    logic jal_wd_sel;
    logic valid;
  } wb_t;

  ex_t  dec_d;
  logic illegal_d;
  ex_t  ex_q;
  mem_t mem_q;
  wb_t  wb_q;

  // A stalled EX instruction must not commit twice, so MEM receives a bubble
  // while EX is held. A flush overrides this; EX then advances normally.
  logic hold_ex;
  assign hold_ex = stall_e & ~flush_e;

  always_comb begin
    dec_d     = '0;
    branch_d  = 1'b0;
    jump_d    = 1'b0;
    illegal_d = 1'b0;
    if (valid_d) begin
      dec_d.valid = 1'b1;
      case (opcode_d)
        OP_RTYPE: begin
          dec_d.reg_dst = 1'b1;
          dec_d.we_reg  = 1'b1;
          dec_d.alu_op  = ALU_FUNCT;
        end
        OP_ADDI: begin
          dec_d.we_reg  = 1'b1;
          dec_d.alu_src = 1'b1;
          dec_d.alu_op  = ALU_ADD;
        end
        OP_BEQ: begin
          branch_d     = 1'b1;
          dec_d.alu_op = ALU_SUB;
        end
        OP_J: jump_d = 1'b1;
        OP_JAL: begin
          jump_d           = 1'b1;
          dec_d.we_reg     = 1'b1;
          dec_d.jal_wd_sel = 1'b1;
          dec_d.jal_wa_sel = 1'b1;
        end
        OP_LW: begin
          dec_d.we_reg  = 1'b1;
          dec_d.alu_src = 1'b1;
          dec_d.dm2reg  = 1'b1;
          dec_d.alu_op  = ALU_ADD;
        end
        OP_SW: begin
          dec_d.alu_src = 1'b1;
          dec_d.we_dm   = 1'b1;
          dec_d.alu_op  = ALU_ADD;
        end
        OP_ANDI, OP_ORI: begin
          if (EXT_ITYPE) begin
            dec_d.we_reg   = 1'b1;
            dec_d.alu_src  = 1'b1;
            dec_d.ext_zero = 1'b1;
            dec_d.alu_op   = (opcode_d == OP_ORI) ? ALU_OR : ALU_AND;
          end else begin
            illegal_d = 1'b1;
          end
        end
        OP_SLTI: begin
          if (EXT_ITYPE) begin
            dec_d.we_reg  = 1'b1;
            dec_d.alu_src = 1'b1;
            dec_d.alu_op  = ALU_SLT;
          end else begin
            illegal_d = 1'b1;
          end
        end
        default: illegal_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (flush_e) begin
      ex_q <= '0;
    end else if (!stall_e) begin
      ex_q <= dec_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (hold_ex) begin
      mem_q <= '0;
    end else begin
      mem_q.we_dm      <= ex_q.we_dm;
      mem_q.we_reg     <= ex_q.we_reg;
      mem_q.dm2reg     <= ex_q.dm2reg;
      mem_q.jal_wd_sel <= ex_q.jal_wd_sel;
      mem_q.valid      <= ex_q.valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      wb_q.we_reg     <= mem_q.we_reg;
      wb_q.dm2reg     <= mem_q.dm2reg;
      wb_q.jal_wd_sel <= mem_q.jal_wd_sel;
      wb_q.valid      <= mem_q.valid;
    end
  end

  assign reg_dst_e    = ex_q.reg_dst;
  assign alu_src_e    = ex_q.alu_src;
  assign ext_zero_e   = ex_q.ext_zero;
  assign jal_wa_sel_e = ex_q.jal_wa_sel;
  assign alu_op_e     = ex_q.alu_op;
  assign we_reg_e     = ex_q.we_reg;
  assign dm2reg_e     = ex_q.dm2reg;
  assign valid_e      = ex_q.valid;
  assign we_dm_m      = mem_q.we_dm;
  assign we_reg_m     = mem_q.we_reg;
  assign dm2reg_m     = mem_q.dm2reg;
  assign jal_wd_sel_m = mem_q.jal_wd_sel;
  assign valid_m      = mem_q.valid;
  assign we_reg_w     = wb_q.we_reg;
  assign dm2reg_w     = wb_q.dm2reg;
  assign jal_wd_sel_w = wb_q.jal_wd_sel;
  assign valid_w      = wb_q.valid;

`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
  logic ill_e, ill_m, ill_w, seen_q;

  // The illegal bit follows the same hold/bubble rules as the bundle it
  // belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_e  <= 1'b0;
      ill_m  <= 1'b0;
      ill_w  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      if (flush_e) begin
        ill_e <= 1'b0;
      end else if (!stall_e) begin
        ill_e <= illegal_d;
      end
      ill_m  <= hold_ex ? 1'b0 : ill_e;
      ill_w  <= ill_m;
      seen_q <= seen_q | illegal_w;
    end
  end

  assign illegal_w    = wb_q.valid & ill_w;
  assign illegal_seen = seen_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_d;
  assign illegal_w      = 1'b0;
  assign illegal_seen   = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: self-checking bench for ctrl_pipe. It runs one instance with
// the extended I-type set enabled and one instance with it disabled, both on
// the same stimulus. The reference model tracks which opcode sits in each
// pipeline stage and decodes that opcode from the instruction table.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode_d = '0;
  logic       valid_d = 1'b0;
  logic       stall_e = 1'b0;
  logic       flush_e = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic       branch_d_a, jump_d_a, reg_dst_e_a, alu_src_e_a, ext_zero_e_a, jal_wa_sel_e_a;
  logic [2:0] alu_op_e_a;
  logic       we_reg_e_a, dm2reg_e_a, valid_e_a, we_dm_m_a, we_reg_m_a, dm2reg_m_a;
  logic       jal_wd_sel_m_a, valid_m_a, we_reg_w_a, dm2reg_w_a, jal_wd_sel_w_a, valid_w_a;
  logic       illegal_w_a, illegal_seen_a;

  logic       branch_d_b, jump_d_b, reg_dst_e_b, alu_src_e_b, ext_zero_e_b, jal_wa_sel_e_b;
  logic [2:0] alu_op_e_b;
  logic       we_reg_e_b, dm2reg_e_b, valid_e_b, we_dm_m_b, we_reg_m_b, dm2reg_m_b;
  logic       jal_wd_sel_m_b, valid_m_b, we_reg_w_b, dm2reg_w_b, jal_wd_sel_w_b, valid_w_b;
  logic       illegal_w_b, illegal_seen_b;

  ctrl_pipe #(.EXT_ITYPE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode_d(opcode_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .branch_d(branch_d_a), .jump_d(jump_d_a),
    .reg_dst_e(reg_dst_e_a), .alu_src_e(alu_src_e_a), .ext_zero_e(ext_zero_e_a),
    .jal_wa_sel_e(jal_wa_sel_e_a), .alu_op_e(alu_op_e_a), .we_reg_e(we_reg_e_a),
    .dm2reg_e(dm2reg_e_a), .valid_e(valid_e_a),
    .we_dm_m(we_dm_m_a), .we_reg_m(we_reg_m_a), .dm2reg_m(dm2reg_m_a),
    .jal_wd_sel_m(jal_wd_sel_m_a), .valid_m(valid_m_a),
    .we_reg_w(we_reg_w_a), .dm2reg_w(dm2reg_w_a), .jal_wd_sel_w(jal_wd_sel_w_a),
    .valid_w(valid_w_a), .illegal_w(illegal_w_a), .illegal_seen(illegal_seen_a)
  );

  ctrl_pipe #(.EXT_ITYPE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode_d(opcode_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .branch_d(branch_d_b), .jump_d(jump_d_b),
    .reg_dst_e(reg_dst_e_b), .alu_src_e(alu_src_e_b), .ext_zero_e(ext_zero_e_b),
    .jal_wa_sel_e(jal_wa_sel_e_b), .alu_op_e(alu_op_e_b), .we_reg_e(we_reg_e_b),
    .dm2reg_e(dm2reg_e_b), .valid_e(valid_e_b),
    .we_dm_m(we_dm_m_b), .we_reg_m(we_reg_m_b), .dm2reg_m(dm2reg_m_b),
    .jal_wd_sel_m(jal_wd_sel_m_b), .valid_m(valid_m_b),
    .we_reg_w(we_reg_w_b), .dm2reg_w(dm2reg_w_b), .jal_wd_sel_w(jal_wd_sel_w_b),
    .valid_w(valid_w_b), .illegal_w(illegal_w_b), .illegal_seen(illegal_seen_b)
  );

  // Observed outputs, packed as {d(2), e(10), m(5), w(4), illegal(2)}.
  logic [22:0] act_a, act_b;
  assign act_a = {branch_d_a, jump_d_a, reg_dst_e_a, alu_src_e_a, ext_zero_e_a,
                  jal_wa_sel_e_a, alu_op_e_a, we_reg_e_a, dm2reg_e_a, valid_e_a,
                  we_dm_m_a, we_reg_m_a, dm2reg_m_a, jal_wd_sel_m_a, valid_m_a,
                  we_reg_w_a, dm2reg_w_a, jal_wd_sel_w_a, valid_w_a,
                  illegal_w_a, illegal_seen_a};
  assign act_b = {branch_d_b, jump_d_b, reg_dst_e_b, alu_src_e_b, ext_zero_e_b,
                  jal_wa_sel_e_b, alu_op_e_b, we_reg_e_b, dm2reg_e_b, valid_e_b,
                  we_dm_m_b, we_reg_m_b, dm2reg_m_b, jal_wd_sel_m_b, valid_m_b,
                  we_reg_w_b, dm2reg_w_b, jal_wd_sel_w_b, valid_w_b,
                  illegal_w_b, illegal_seen_b};

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       reg_dst, alu_src, ext_zero, jal_wa_sel;
    logic [2:0] alu_op;
    logic       we_reg, dm2reg, we_dm, jal_wd_sel, branch, jump, valid, illegal;
  } ctl_t;

  typedef struct packed {
    logic       v;
    logic [5:0] op;
  } slot_t;

  slot_t ex_s = '0, mem_s = '0, wb_s = '0;
  logic  seen_a = 1'b0, seen_b = 1'b0;

  function automatic ctl_t ref_dec(input logic [5:0] op, input logic v, input logic ext);
    ctl_t c;
    c = '0;
    if (v) begin
      c.valid = 1'b1;
      case (op)
        6'h00: begin c.reg_dst = 1; c.we_reg = 1; c.alu_op = 3'd2; end
        6'h08: begin c.we_reg = 1; c.alu_src = 1; end
        6'h04: begin c.branch = 1; c.alu_op = 3'd1; end
        6'h02: c.jump = 1;
        6'h03: begin c.jump = 1; c.we_reg = 1; c.jal_wd_sel = 1; c.jal_wa_sel = 1; end
        6'h23: begin c.we_reg = 1; c.alu_src = 1; c.dm2reg = 1; end
        6'h2B: begin c.alu_src = 1; c.we_dm = 1; end
        6'h0C: if (ext) begin c.we_reg = 1; c.alu_src = 1; c.ext_zero = 1; c.alu_op = 3'd3; end
               else c.illegal = 1;
        6'h0D: if (ext) begin c.we_reg = 1; c.alu_src = 1; c.ext_zero = 1; c.alu_op = 3'd4; end
               else c.illegal = 1;
        6'h0A: if (ext) begin c.we_reg = 1; c.alu_src = 1; c.alu_op = 3'd5; end
               else c.illegal = 1;
        default: c.illegal = 1;
      endcase
    end
    return c;
  endfunction

  function automatic logic [22:0] exp_all(input logic ext);
    ctl_t d, e, m, w;
    logic [1:0] il;
    d  = ref_dec(opcode_d, valid_d, ext);
    e  = ref_dec(ex_s.op, ex_s.v, ext);
    m  = ref_dec(mem_s.op, mem_s.v, ext);
    w  = ref_dec(wb_s.op, wb_s.v, ext);
    il = 2'b00;
`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
    il = {w.valid & w.illegal, ext ? seen_a : seen_b};
`endif
    return {d.branch, d.jump, e.reg_dst, e.alu_src, e.ext_zero, e.jal_wa_sel,
            e.alu_op, e.we_reg, e.dm2reg, e.valid,
            m.we_dm, m.we_reg, m.dm2reg, m.jal_wd_sel, m.valid,
            w.we_reg, w.dm2reg, w.jal_wd_sel, w.valid, il};
  endfunction

  task automatic model_clear();
    ex_s = '0; mem_s = '0; wb_s = '0; seen_a = 1'b0; seen_b = 1'b0;
  endtask

  // Set ID-stage inputs, then wait to mid-cycle for sampling.
  task automatic drive(input logic [5:0] op, input logic v, input logic st, input logic fl);
    opcode_d = op; valid_d = v; stall_e = st; flush_e = fl;
    @(negedge clk);
  endtask

  // Clock edge: move the model one cycle using the pipeline rules.
  task automatic advance();
    ctl_t wa, wb;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      wa = ref_dec(wb_s.op, wb_s.v, 1'b1);
      wb = ref_dec(wb_s.op, wb_s.v, 1'b0);
`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
      seen_a = seen_a | wa.illegal;
      seen_b = seen_b | wb.illegal;
`endif
      wb_s  = mem_s;
      mem_s = (stall_e && !flush_e) ? slot_t'('0) : ex_s;
      if (flush_e) ex_s = '0;
      else if (!stall_e) ex_s = '{v: valid_d, op: opcode_d};
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    opcode_d = 6'h23; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (act_a !== 23'h0) $display("FAIL reset_a got %h exp %h", act_a, 23'h0); else n_pass++;
    n_checks++;
    if (act_b !== 23'h0) $display("FAIL reset_b got %h exp %h", act_b, 23'h0); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [5:0] prog [6];
    prog = '{6'h23, 6'h2B, 6'h08, 6'h00, 6'h04, 6'h03};
    for (int i = 0; i < 10; i++) begin
      if (i < 6) drive(prog[i], 1'b1, 1'b0, 1'b0);
      else drive(6'h00, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (act_a !== exp_all(1'b1)) $display("FAIL stream_a cyc %0d got %h exp %h", i, act_a, exp_all(1'b1)); else n_pass++;
      n_checks++;
      if (act_b !== exp_all(1'b0)) $display("FAIL stream_b cyc %0d got %h exp %h", i, act_b, exp_all(1'b0)); else n_pass++;
      if (i == 1) begin
        n_checks++;
        if ({dm2reg_e_a, we_reg_e_a} !== 2'b11) $display("FAIL lw_e got %b exp 11", {dm2reg_e_a, we_reg_e_a}); else n_pass++;
      end
      if (i == 2) begin
        n_checks++;
        if ({dm2reg_m_a, we_reg_m_a} !== 2'b11) $display("FAIL lw_m got %b exp 11", {dm2reg_m_a, we_reg_m_a}); else n_pass++;
      end
      if (i == 3) begin
        n_checks++;
        if ({dm2reg_w_a, we_reg_w_a, we_dm_m_a} !== 3'b111) $display("FAIL lw_w_sw_m got %b exp 111", {dm2reg_w_a, we_reg_w_a, we_dm_m_a}); else n_pass++;
      end
      if (i == 5) begin
        n_checks++;
        if (jump_d_a !== 1'b1) $display("FAIL jal_jump_d got %b exp 1", jump_d_a); else n_pass++;
      end
      if (i == 6) begin
        n_checks++;
        if (jal_wa_sel_e_a !== 1'b1) $display("FAIL jal_wa_sel_e got %b exp 1", jal_wa_sel_e_a); else n_pass++;
      end
      if (i == 8) begin
        n_checks++;
        if (jal_wd_sel_w_a !== 1'b1) $display("FAIL jal_wd_sel_w got %b exp 1", jal_wd_sel_w_a); else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_stall();
    int lw_commits = 0;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: drive(6'h08, 1'b1, 1'b0, 1'b0);
        1: drive(6'h23, 1'b1, 1'b0, 1'b0);
        2, 3: drive(6'h2B, 1'b1, 1'b1, 1'b0);
        4: drive(6'h2B, 1'b1, 1'b0, 1'b0);
        default: drive(6'h00, 1'b0, 1'b0, 1'b0);
      endcase
      n_checks++;
      if (act_a !== exp_all(1'b1)) $display("FAIL stall_a cyc %0d got %h exp %h", i, act_a, exp_all(1'b1)); else n_pass++;
      if (i >= 2 && i <= 4) begin
        n_checks++;
        if ({dm2reg_e_a, valid_e_a} !== 2'b11) $display("FAIL stall_hold_e cyc %0d got %b exp 11", i, {dm2reg_e_a, valid_e_a}); else n_pass++;
      end
      if (i == 3 || i == 4) begin
        n_checks++;
        if ({we_reg_m_a, valid_m_a} !== 2'b00) $display("FAIL stall_bubble_m cyc %0d got %b exp 00", i, {we_reg_m_a, valid_m_a}); else n_pass++;
      end
      if (valid_w_a === 1'b1 && dm2reg_w_a === 1'b1) lw_commits++;
      advance();
    end
    n_checks++;
    if (lw_commits !== 1) $display("FAIL stall_lw_commits got %0d exp 1", lw_commits); else n_pass++;
  endtask

  task automatic test_stall_flush();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(6'h2B, 1'b1, 1'b0, 1'b0);
        1: drive(6'h08, 1'b1, 1'b1, 1'b1);
        default: drive(6'h00, 1'b0, 1'b0, 1'b0);
      endcase
      n_checks++;
      if (act_a !== exp_all(1'b1)) $display("FAIL flush_a cyc %0d got %h exp %h", i, act_a, exp_all(1'b1)); else n_pass++;
      if (i == 2) begin
        n_checks++;
        if ({valid_e_a, we_dm_m_a, valid_m_a} !== 3'b011) $display("FAIL flush_stall got %b exp 011", {valid_e_a, we_dm_m_a, valid_m_a}); else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_ext_itype();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(6'h0D, 1'b1, 1'b0, 1'b0);
      else drive(6'h00, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (act_a !== exp_all(1'b1)) $display("FAIL ext_a cyc %0d got %h exp %h", i, act_a, exp_all(1'b1)); else n_pass++;
      n_checks++;
      if (act_b !== exp_all(1'b0)) $display("FAIL ext_b cyc %0d got %h exp %h", i, act_b, exp_all(1'b0)); else n_pass++;
      if (i == 1) begin
        n_checks++;
        if ({alu_op_e_a, ext_zero_e_a, we_reg_e_a} !== 5'b10011) $display("FAIL ori_on got %b exp 10011", {alu_op_e_a, ext_zero_e_a, we_reg_e_a}); else n_pass++;
        n_checks++;
        if ({alu_op_e_b, ext_zero_e_b, we_reg_e_b, alu_src_e_b, valid_e_b} !== 7'b0000001) $display("FAIL ori_off got %b exp 0000001", {alu_op_e_b, ext_zero_e_b, we_reg_e_b, alu_src_e_b, valid_e_b}); else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_illegal();
    logic trap;
`ifdef CTRL_PIPE_ILLEGAL_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    for (int i = 0; i < 7; i++) begin
      if (i == 0) drive(6'h3F, 1'b1, 1'b0, 1'b0);
      else drive(6'h00, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (act_a !== exp_all(1'b1)) $display("FAIL illegal_a cyc %0d got %h exp %h", i, act_a, exp_all(1'b1)); else n_pass++;
      n_checks++;
      if ({illegal_w_a, illegal_seen_a} !== {trap && i == 3, trap && i >= 4})
        $display("FAIL illegal_flags cyc %0d got %b exp %b", i, {illegal_w_a, illegal_seen_a}, {trap && i == 3, trap && i >= 4});
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_random(input int cycles);
    logic [5:0] tbl [11];
    logic [5:0] op;
    int k;
    tbl = '{6'h00, 6'h08, 6'h04, 6'h02, 6'h03, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0A, 6'h3F};
    for (int i = 0; i < cycles; i++) begin
      k = $urandom_range(0, 11);
      op = (k == 11) ? 6'($urandom) : tbl[k];
      drive(op, $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
      n_checks++;
      if (act_a !== exp_all(1'b1)) $display("FAIL random_a cyc %0d got %h exp %h", i, act_a, exp_all(1'b1)); else n_pass++;
      n_checks++;
      if (act_b !== exp_all(1'b0)) $display("FAIL random_b cyc %0d got %h exp %h", i, act_b, exp_all(1'b0)); else n_pass++;
      advance();
    end
  endtask

  task automatic test_reset_mid();
    opcode_d = 6'h00; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if (act_a !== 23'h0) $display("FAIL reset_mid_a got %h exp %h", act_a, 23'h0); else n_pass++;
    n_checks++;
    if (act_b !== 23'h0) $display("FAIL reset_mid_b got %h exp %h", act_b, 23'h0); else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(6'h08, 1'b1, 1'b0, 1'b0);
      else drive(6'h00, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (act_a !== exp_all(1'b1)) $display("FAIL post_reset_a cyc %0d got %h exp %h", i, act_a, exp_all(1'b1)); else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (valid_e_a !== 1'b1) $display("FAIL post_reset_valid_e got %b exp 1", valid_e_a); else n_pass++;
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_stall_flush();
    test_ext_itype();
    test_illegal();
    test_random(400);
    test_reset_mid();
    test_random(200);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
